// File: rtl/epcl_pkg.sv
// Shared types and helpers for the per-channel FIFO arbiter.
package epcl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEL    = 3'd1,
    SETTLE = 3'd2,
    POP    = 3'd3,
    SEND   = 3'd4
  } arb_state_t;

  localparam int MAX_CH = 8;

  // Next index strictly after ptr whose mask bit is set, wrapping at MAX_CH-1.
  function automatic logic [2:0] next_rr(input logic [MAX_CH-1:0] mask,
                                         input logic [2:0]        ptr);
    logic [2:0] idx;
    logic [2:0] res;
    logic       found;
    idx   = '0;
    res   = ptr;
    found = 1'b0;
    for (int off = 1; off <= MAX_CH; off++) begin
      idx = 3'((int'(ptr) + off) % MAX_CH);
      if (!found && mask[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/epcl_rr_pick.sv
// Masked round-robin priority picker: first set req bit at or after ptr, wrapping.
module epcl_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] grant,
  output logic         any
);

  logic [N-1:0] rot;
  int           sum;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    sum   = 0;
    // rot[k] corresponds to req[(ptr + k) mod N]
    rot   = N'({req, req} >> ptr);
    for (int k = 0; k < N; k++) begin
      if (!any && rot[k]) begin
        any = 1'b1;
        sum = int'(ptr) + k;
        if (sum >= N) sum = sum - N;
        grant = W'(sum);
      end
    end
  end

endmodule

// File: rtl/epcl_ch_arbiter.sv
// Drains per-channel sample FIFOs into one AXI-Stream master, either round-robin
// single-beat packets or one ordered packet per conversion frame.
module epcl_ch_arbiter
  import epcl_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4,
  parameter int CH_W       = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            ch_en,
  input  logic                         frame_mode,
  input  logic [NUM_CH-1:0]            fifo_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] fifo_rd_data,
  output logic [NUM_CH-1:0]            fifo_rd_en,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic [CH_W-1:0]              m_axis_tuser,
  output logic                         m_axis_tlast,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         busy,
  output logic [31:0]                  frame_cnt
);

  localparam logic [MAX_CH-1:0] ALL_CH = MAX_CH'((1 << NUM_CH) - 1);

  arb_state_t            state, state_nx;
  logic [NUM_CH-1:0]     en_q;
  logic [NUM_CH-1:0]     sent;
  logic                  frame_q;
  logic [CH_W-1:0]       g;
  logic [CH_W-1:0]       rr_ptr;
  logic [CH_W-1:0]       hi_ch;
  logic [CH_W-1:0]       pick_grant;
  logic [CH_W-1:0]       pick_ptr;
  logic [NUM_CH-1:0]     pick_req;
  logic                  pick_any;
  logic                  g_valid;
  logic                  handshake;
  logic                  start;
  logic [DATA_WIDTH-1:0] g_data;

  always_comb begin
    hi_ch  = '0;
    g_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (en_q[k]) hi_ch = CH_W'(k);
      if (int'(g) == k) g_data = fifo_rd_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Frame mode walks the unsent enabled channels from index 0 upward.
  assign pick_req  = frame_q ? (en_q & ~sent) : (fifo_valid & en_q);
  assign pick_ptr  = frame_q ? '0 : rr_ptr;
  assign g_valid   = fifo_valid[g];
  assign handshake = (state == SEND) && m_axis_tready;
  assign start     = frame_mode ? ((ch_en != '0) && ((fifo_valid & ch_en) == ch_en))
                                : (|(fifo_valid & ch_en));

  epcl_rr_pick #(
    .N (NUM_CH),
    .W (CH_W)
  ) u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .grant (pick_grant),
    .any   (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    fifo_rd_en = '0;
    case (state)
      IDLE:   if (start) state_nx = SEL;
      SEL:    state_nx = pick_any ? SETTLE : IDLE;
      SETTLE: state_nx = POP;
      POP: begin
        // A grant that lost valid is only possible through external misuse; reselect.
        if (g_valid) begin
          fifo_rd_en[g] = 1'b1;
          state_nx      = SEND;
        end else begin
          state_nx = SEL;
        end
      end
      SEND: begin
        if (m_axis_tready) state_nx = (!frame_q || m_axis_tlast) ? IDLE : SEL;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q         <= '0;
      frame_q      <= 1'b0;
      sent         <= '0;
      g            <= '0;
      rr_ptr       <= '0;
      m_axis_tdata <= '0;
      m_axis_tuser <= '0;
      m_axis_tlast <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          en_q    <= ch_en;
          frame_q <= frame_mode;
          sent    <= '0;
        end
        SEL: if (pick_any) g <= pick_grant;
        POP: begin
          if (g_valid) begin
            m_axis_tdata <= g_data;
            m_axis_tuser <= g;
            m_axis_tlast <= !frame_q || (g == hi_ch);
            sent[g]      <= 1'b1;
          end
        end
        default: ;
      endcase
      if (handshake) begin
        if (m_axis_tlast) frame_cnt <= frame_cnt + 32'd1;
        if (!frame_q) rr_ptr <= CH_W'(next_rr(ALL_CH, 3'(g)));
      end
    end
  end

  assign m_axis_tvalid = (state == SEND);
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_epcl_ch_arbiter.sv
// Directed bench for epcl_ch_arbiter with a behavioural FIFO model per channel.
module tb_epcl_ch_arbiter;

  localparam int DW  = 16;
  localparam int NCH = 4;
  localparam int CW  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH-1:0]    ch_en = '0;
  logic              frame_mode = 1'b0;
  logic [NCH-1:0]    fifo_valid = '0;
  logic [NCH*DW-1:0] fifo_rd_data = '0;
  logic [NCH-1:0]    fifo_rd_en;
  logic [DW-1:0]     m_axis_tdata;
  logic [CW-1:0]     m_axis_tuser;
  logic              m_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b0;
  logic              busy;
  logic [31:0]       frame_cnt;

  epcl_ch_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_CH     (NCH),
    .CH_W       (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ch_en         (ch_en),
    .frame_mode    (frame_mode),
    .fifo_valid    (fifo_valid),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_rd_en    (fifo_rd_en),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .frame_cnt     (frame_cnt)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] q [NCH][$];
  logic [DW-1:0] bdat [$];
  logic [CW-1:0] busr [$];
  logic          blst [$];
  int            pops [NCH];
  int            bad_pop;
  int            checks;
  int            failures;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic upd_valid();
    for (int i = 0; i < NCH; i++) fifo_valid[i] = (q[i].size() != 0);
  endtask

  task automatic push(input int ch, input logic [DW-1:0] v);
    q[ch].push_back(v);
    upd_valid();
  endtask

  task automatic clear_log();
    bdat.delete();
    busr.delete();
    blst.delete();
    for (int i = 0; i < NCH; i++) pops[i] = 0;
    bad_pop = 0;
  endtask

  // One clock: sample at negedge, let the edge happen, then update the FIFO model.
  task automatic step();
    logic [NCH-1:0] pop;
    pop = fifo_rd_en;
    if (rst_n && m_axis_tvalid && m_axis_tready) begin
      bdat.push_back(m_axis_tdata);
      busr.push_back(m_axis_tuser);
      blst.push_back(m_axis_tlast);
    end
    for (int i = 0; i < NCH; i++) begin
      if (pop[i]) begin
        pops[i]++;
        if (!fifo_valid[i]) bad_pop++;
      end
    end
    if ($countones(pop) > 1) bad_pop++;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NCH; i++) begin
      if (q[i].size() != 0) begin
        fifo_rd_data[i*DW +: DW] = q[i][0];
        if (pop[i]) q[i].delete(0);
      end
    end
    upd_valid();
  endtask

  task automatic run_beats(input string tag, input int n, input int budget);
    int cyc;
    cyc = 0;
    while (bdat.size() < n && cyc < budget) begin
      step();
      cyc++;
    end
    chk(tag, bdat.size(), n);
    while (bdat.size() < n) begin
      bdat.push_back(16'hDEAD);
      busr.push_back('0);
      blst.push_back(1'b0);
    end
  endtask

  initial begin
    logic [DW-1:0] d0;
    logic [CW-1:0] u0;
    logic          l0;
    int            unstable;
    int            popsum;
    int            cyc;
    int            seq_err;

    checks   = 0;
    failures = 0;
    clear_log();

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin, two single-beat packets
    clear_log();
    ch_en = 4'hF; frame_mode = 1'b0; m_axis_tready = 1'b1;
    push(0, 16'h0001);
    push(2, 16'h0202);
    run_beats("rr_beats", 2, 40);
    chk("rr_b0_data", bdat[0], 16'h0001);
    chk("rr_b0_user", busr[0], 0);
    chk("rr_b0_last", blst[0], 1);
    chk("rr_b1_data", bdat[1], 16'h0202);
    chk("rr_b1_user", busr[1], 2);
    chk("rr_b1_last", blst[1], 1);
    step();
    chk("rr_frame_cnt", frame_cnt, 2);

    // Frame mode with ch2 disabled
    clear_log();
    ch_en = 4'b1011; frame_mode = 1'b1;
    push(2, 16'h0022);
    push(0, 16'h00A0);
    push(1, 16'h00A1);
    push(3, 16'h00A3);
    run_beats("fm_beats", 3, 60);
    chk("fm_b0", {busr[0], blst[0], bdat[0]}, {2'd0, 1'b0, 16'h00A0});
    chk("fm_b1", {busr[1], blst[1], bdat[1]}, {2'd1, 1'b0, 16'h00A1});
    chk("fm_b2", {busr[2], blst[2], bdat[2]}, {2'd3, 1'b1, 16'h00A3});
    repeat (3) step();
    chk("fm_ch2_pops", pops[2], 0);
    chk("fm_ch2_level", q[2].size(), 1);
    chk("fm_frame_cnt", frame_cnt, 3);
    // Drain the disabled channel with a round-robin packet
    clear_log();
    ch_en = 4'b0100; frame_mode = 1'b0;
    run_beats("drain2_beats", 1, 30);
    chk("drain2_b0", {busr[0], bdat[0]}, {2'd2, 16'h0022});
    step();
    chk("drain2_frame_cnt", frame_cnt, 4);

    // Frame waits for every enabled channel
    clear_log();
    ch_en = 4'hF; frame_mode = 1'b1;
    push(0, 16'h00B0);
    push(1, 16'h00B1);
    push(2, 16'h00B2);
    repeat (10) step();
    chk("wait_tvalid", m_axis_tvalid, 0);
    chk("wait_busy", busy, 0);
    chk("wait_pops", pops[0] + pops[1] + pops[2], 0);
    push(3, 16'h00B3);
    repeat (3) step();
    chk("lat_tvalid_3", m_axis_tvalid, 0);
    step();
    chk("lat_tvalid_4", m_axis_tvalid, 1);
    chk("lat_tuser_4", m_axis_tuser, 0);
    run_beats("wait_beats", 4, 40);
    chk("wait_b3", {busr[3], blst[3], bdat[3]}, {2'd3, 1'b1, 16'h00B3});
    chk("wait_b0", {busr[0], blst[0], bdat[0]}, {2'd0, 1'b0, 16'h00B0});

    // Backpressure on beat 2 of a frame
    clear_log();
    push(0, 16'h00C0);
    push(1, 16'h00C1);
    push(2, 16'h00C2);
    push(3, 16'h00C3);
    run_beats("bp_first", 1, 30);
    cyc = 0;
    while (!m_axis_tvalid && cyc < 20) begin
      step();
      cyc++;
    end
    chk("bp_tvalid", m_axis_tvalid, 1);
    m_axis_tready = 1'b0;
    d0 = m_axis_tdata; u0 = m_axis_tuser; l0 = m_axis_tlast;
    popsum = pops[0] + pops[1] + pops[2] + pops[3];
    unstable = 0;
    repeat (20) begin
      step();
      if (!m_axis_tvalid || m_axis_tdata !== d0 || m_axis_tuser !== u0 || m_axis_tlast !== l0)
        unstable++;
    end
    chk("bp_stable", unstable, 0);
    chk("bp_held_beat", {u0, l0, d0}, {2'd1, 1'b0, 16'h00C1});
    chk("bp_no_pop", pops[0] + pops[1] + pops[2] + pops[3] - popsum, 0);
    m_axis_tready = 1'b1;
    run_beats("bp_beats", 4, 40);
    chk("bp_pops", {8'(pops[0]), 8'(pops[1]), 8'(pops[2]), 8'(pops[3])}, 32'h01010101);
    chk("bp_levels", q[0].size() + q[1].size() + q[2].size() + q[3].size(), 0);
    chk("bp_b3", {busr[3], blst[3], bdat[3]}, {2'd3, 1'b1, 16'h00C3});
    step();
    chk("bp_frame_cnt", frame_cnt, 6);

    // Reset mid-frame while a beat is held in SEND
    clear_log();
    for (int i = 0; i < NCH; i++) push(i, 16'(16'h00D0 + i));
    for (int i = 0; i < NCH; i++) push(i, 16'(16'h00E0 + i));
    run_beats("mr_first", 2, 40);
    cyc = 0;
    while (!m_axis_tvalid && cyc < 20) begin
      step();
      cyc++;
    end
    m_axis_tready = 1'b0;
    step();
    chk("mr_pre_tvalid", m_axis_tvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("mr_tvalid", m_axis_tvalid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_frame_cnt", frame_cnt, 0);
    step();
    step();
    rst_n = 1'b1;
    m_axis_tready = 1'b1;
    clear_log();
    run_beats("mr_beats", 4, 40);
    chk("mr_b0", {busr[0], bdat[0]}, {2'd0, 16'h00E0});
    chk("mr_b2", {busr[2], bdat[2]}, {2'd2, 16'h00E2});
    chk("mr_b3", {busr[3], blst[3], bdat[3]}, {2'd3, 1'b1, 16'h00D3});
    chk("mr_ch3_level", q[3].size(), 1);
    clear_log();
    ch_en = 4'b1000; frame_mode = 1'b0;
    run_beats("mr_drain", 1, 30);
    chk("mr_drain_b0", {busr[0], bdat[0]}, {2'd3, 16'h00E3});
    step();
    chk("mr_frame_cnt_after", frame_cnt, 2);

    // Round-robin fairness with all channels backlogged
    clear_log();
    ch_en = 4'hF; frame_mode = 1'b0;
    for (int k = 0; k < 10; k++)
      for (int i = 0; i < NCH; i++) push(i, 16'((i << 8) | k));
    run_beats("fair_beats", 40, 400);
    seq_err = 0;
    for (int i = 0; i < 40; i++) begin
      if (busr[i] !== CW'(i % 4)) seq_err++;
      if (bdat[i] !== 16'(((i % 4) << 8) | (i / 4))) seq_err++;
    end
    chk("fair_sequence", seq_err, 0);
    chk("fair_pops", {8'(pops[0]), 8'(pops[1]), 8'(pops[2]), 8'(pops[3])}, 32'h0A0A0A0A);
    step();
    chk("fair_frame_cnt", frame_cnt, 42);
    chk("fair_bad_pop", bad_pop, 0);
    chk("end_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
